// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for the 3-stage RV32I pipeline (IF, DE, MW). It turns
// hazard requests into the enable, flush and next-PC select controls for the
// PC register, the IF/DE register and the DE/MW register. It also puts a
// bound on data-memory waits (timeout trap) and counts stall cycles.
//
// Parameters:
//   TIMEOUT     maximum MEM_WAIT cycles before a timeout trap (>= 2)
//   CNT_W       width of the wait counter
//
// Ports:
//   clk         pipeline clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_use    load in DE, dependent instruction in IF
//   br_taken    branch/jump in DE resolved taken
//   dmem_req    MW-stage load/store active this cycle
//   dmem_ack    data memory completes the MW access this cycle
//   trap_req    level trap request from CSR, held until trap_take
//   pc_en       PC register load enable
//   pc_sel      next-PC select: 00 PC+4, 01 branch target, 10 trap vector
//   fd_en       IF/DE register enable
//   fd_flush    load NOP into IF/DE (dominates fd_en)
//   dm_en       DE/MW register enable
//   dm_flush    load NOP into DE/MW (dominates dm_en)
//   trap_take   one-cycle pulse: CSR captures mepc and cause
//   trap_cause  registered cause: 00 CSR request, 01 dmem timeout
//   dmem_abort  one-cycle pulse: memory drops the outstanding access
//   stall_cnt   wrapping count of cycles with pc_en = 0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        trap_req,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        fd_en,
    output logic        fd_flush,
    output logic        dm_en,
    output logic        dm_flush,
    output logic        trap_take,
    output logic [1:0]  trap_cause,
    output logic        dmem_abort,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;

    localparam logic [1:0] CAUSE_CSR     = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_nextWaitCnt;
    logic [1:0]       r_trapCause;
    logic [1:0]       w_nextTrapCause;
    logic [31:0]      r_stallCnt;
    logic             w_evalRun;

    // State, wait counter and latched trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_waitCnt   <= '0;
            r_trapCause <= CAUSE_CSR;
        end else begin
            r_state     <= w_nextState;
            r_waitCnt   <= w_nextWaitCnt;
            r_trapCause <= w_nextTrapCause;
        end
    end

    // Next-state and control outputs. The RUN priorities 2-5 are shared
    // between a normal RUN cycle and the MEM_WAIT release cycle. w_evalRun
    // selects them once the memory stall has been ruled out.
    always_comb begin
        pc_en           = 1'b1;
        pc_sel          = SEL_PC4;
        fd_en           = 1'b1;
        fd_flush        = 1'b0;
        dm_en           = 1'b1;
        dm_flush        = 1'b0;
        trap_take       = 1'b0;
        dmem_abort      = 1'b0;
        w_nextState     = r_state;
        w_nextWaitCnt   = r_waitCnt;
        w_nextTrapCause = r_trapCause;
        w_evalRun       = 1'b0;

        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    pc_en         = 1'b0;
                    fd_en         = 1'b0;
                    dm_en         = 1'b0;
                    w_nextState   = MEM_WAIT;
                    w_nextWaitCnt = CNT_W'(1);
                end else begin
                    w_evalRun = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (dmem_ack) begin
                    w_evalRun     = 1'b1;
                    w_nextWaitCnt = '0;
                end else if (r_waitCnt == CNT_W'(TIMEOUT)) begin
                    pc_en           = 1'b0;
                    fd_en           = 1'b0;
                    dm_en           = 1'b0;
                    dmem_abort      = 1'b1;
                    w_nextTrapCause = CAUSE_TIMEOUT;
                    w_nextState     = TRAP;
                    w_nextWaitCnt   = '0;
                end else begin
                    pc_en         = 1'b0;
                    fd_en         = 1'b0;
                    dm_en         = 1'b0;
                    w_nextWaitCnt = r_waitCnt + CNT_W'(1);
                end
            end

            TRAP: begin
                pc_sel      = SEL_TRAP;
                fd_flush    = 1'b1;
                dm_flush    = 1'b1;
                trap_take   = 1'b1;
                w_nextState = RUN;
            end

            default: begin
                w_nextState   = RUN;
                w_nextWaitCnt = '0;
            end
        endcase

        // On trap accept, the MW instruction retires. The DE instruction is
        // held so that its PC becomes mepc in the TRAP cycle.
        if (w_evalRun) begin
            w_nextState = RUN;
            if (trap_req) begin
                pc_en           = 1'b0;
                fd_en           = 1'b0;
                dm_flush        = 1'b1;
                w_nextTrapCause = CAUSE_CSR;
                w_nextState     = TRAP;
            end else if (br_taken) begin
                pc_sel   = SEL_BRANCH;
                fd_flush = 1'b1;
            end else if (load_use) begin
                pc_en    = 1'b0;
                fd_flush = 1'b1;
            end
        end
    end

    // Performance counter of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (!pc_en) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign trap_cause = r_trapCause;
    assign stall_cnt  = r_stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl with TIMEOUT = 16. Inputs change
// 1 time unit after the rising edge. The combinational controls are sampled
// on the falling edge. The expected values are hand-computed constants, and
// a running expected stall count is kept alongside them.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        loadUse;
    logic        brTaken;
    logic        dmemReq;
    logic        dmemAck;
    logic        trapReq;
    logic        pcEn;
    logic [1:0]  pcSel;
    logic        fdEn;
    logic        fdFlush;
    logic        dmEn;
    logic        dmFlush;
    logic        trapTake;
    logic [1:0]  trapCause;
    logic        dmemAbort;
    logic [31:0] stallCnt;

    int checks;
    int errors;
    int expStall;

    // Packed view of the combinational controls:
    // {pc_en, pc_sel[1:0], fd_en, fd_flush, dm_en, dm_flush, trap_take, dmem_abort}
    logic [8:0] ctrlBus;
    assign ctrlBus = {pcEn, pcSel, fdEn, fdFlush, dmEn, dmFlush, trapTake, dmemAbort};

    localparam logic [8:0] C_RUN      = 9'b1_00_1_0_1_0_0_0;
    localparam logic [8:0] C_FREEZE   = 9'b0_00_0_0_0_0_0_0;
    localparam logic [8:0] C_ABORT    = 9'b0_00_0_0_0_0_0_1;
    localparam logic [8:0] C_ACCEPT   = 9'b0_00_0_0_1_1_0_0;
    localparam logic [8:0] C_BRANCH   = 9'b1_01_1_1_1_0_0_0;
    localparam logic [8:0] C_LOADUSE  = 9'b0_00_1_1_1_0_0_0;
    localparam logic [8:0] C_TRAP     = 9'b1_10_1_1_1_1_1_0;

    pipeline_hazard_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_use   (loadUse),
        .br_taken   (brTaken),
        .dmem_req   (dmemReq),
        .dmem_ack   (dmemAck),
        .trap_req   (trapReq),
        .pc_en      (pcEn),
        .pc_sel     (pcSel),
        .fd_en      (fdEn),
        .fd_flush   (fdFlush),
        .dm_en      (dmEn),
        .dm_flush   (dmFlush),
        .trap_take  (trapTake),
        .trap_cause (trapCause),
        .dmem_abort (dmemAbort),
        .stall_cnt  (stallCnt)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the hazard request inputs.
    task automatic applyStimulus(input logic lu, input logic br, input logic req,
                                 input logic ack, input logic tr);
        loadUse = lu;
        brTaken = br;
        dmemReq = req;
        dmemAck = ack;
        trapReq = tr;
    endtask

    // Single comparison point: counts the check and reports on a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: check the controls at the falling edge, then move to
    // just after the next rising edge so that the caller can drive new inputs.
    task automatic stepCheck(input string tag, input logic [8:0] expCtrl);
        @(negedge clk);
        checkOutput(tag, {23'd0, ctrlBus}, {23'd0, expCtrl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expStall = 0;

        // Reset with all inputs low.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput("reset_ctrl",  {23'd0, ctrlBus}, {23'd0, C_RUN});
        checkOutput("reset_stall", stallCnt, 32'd0);
        checkOutput("reset_cause", {30'd0, trapCause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle: the PC advances every cycle.
        for (int i = 0; i < 10; i++) begin
            stepCheck("idle_ctrl", C_RUN);
        end
        checkOutput("idle_stall", stallCnt, 32'd0);

        // Load-use: one stall cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("loaduse_ctrl", C_LOADUSE);
        expStall += 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("loaduse_after", C_RUN);
        checkOutput("loaduse_stall", stallCnt, 32'(expStall));

        // Branch and load-use together: the branch wins and there is no stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("br_lu_ctrl", C_BRANCH);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("br_lu_after", C_RUN);
        checkOutput("br_lu_stall", stallCnt, 32'(expStall));

        // Zero-wait memory access: no stall.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepCheck("mem0_ctrl", C_RUN);

        // Memory access acknowledged after 3 frozen cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCheck("mem3_freeze", C_FREEZE);
        end
        expStall += 3;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepCheck("mem3_release", C_RUN);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("mem3_after", C_RUN);
        checkOutput("mem3_stall", stallCnt, 32'(expStall));

        // Branch held during a memory wait is honoured in the release cycle.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCheck("membr_freeze", C_FREEZE);
        end
        expStall += 3;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        stepCheck("membr_release", C_BRANCH);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("membr_after", C_RUN);
        checkOutput("membr_stall", stallCnt, 32'(expStall));

        // Trap request beats branch; TRAP cycle follows.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("trap_accept", C_ACCEPT);
        expStall += 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("trap_cycle", C_TRAP);
        checkOutput("trap_cause_csr", {30'd0, trapCause}, 32'd0);
        stepCheck("trap_after", C_RUN);
        checkOutput("trap_stall", stallCnt, 32'(expStall));

        // Timeout: 16 frozen cycles, an abort in the 17th, then TRAP.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            stepCheck("tmo_freeze", C_FREEZE);
        end
        stepCheck("tmo_abort", C_ABORT);
        expStall += TIMEOUT + 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo_cause", {30'd0, trapCause}, 32'd1);
        stepCheck("tmo_trap", C_TRAP);
        stepCheck("tmo_after", C_RUN);
        checkOutput("tmo_stall", stallCnt, 32'(expStall));

        // Reset asserted in the 5th MEM_WAIT cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCheck("rstwait_freeze", C_FREEZE);
        end
        checkOutput("rstwait_before", {23'd0, ctrlBus}, {23'd0, C_FREEZE});
        #2;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rstwait_ctrl",  {23'd0, ctrlBus}, {23'd0, C_RUN});
        checkOutput("rstwait_stall", stallCnt, 32'd0);
        checkOutput("rstwait_cause", {30'd0, trapCause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            stepCheck("rstwait_idle", C_RUN);
        end
        checkOutput("rstwait_idle_stall", stallCnt, 32'd0);

        // After the reset, a short memory wait still behaves normally.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            stepCheck("post_rst_freeze", C_FREEZE);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepCheck("post_rst_release", C_RUN);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("post_rst_after", C_RUN);
        checkOutput("post_rst_stall", stallCnt, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
